// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS fetch stage
//
// Purpose: data width, next-PC select codes, fetch FSM state encoding and a
// helper that forms the word-scaled, sign-extended branch offset.
package mips_pkg;

  localparam int XLEN = 32;

  // Next-PC select codes driven by the control unit alongside retire.
  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JR  = 2'b10;
  localparam logic [1:0] PC_SEL_J   = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } fetch_state_e;

  // Branch displacement: 16-bit immediate counts words, so sign-extend and
  // shift left by two to get a byte offset.
  function automatic logic [XLEN-1:0] branch_offset(input logic [15:0] imm);
    return {{(XLEN-18){imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/mips_next_pc.sv
// rtl/mips_next_pc.sv - combinational next-PC selection
//
// Purpose: forms the next program counter from the current pc, the jump index
// / branch immediate field of the instruction and the control unit's select.
// Ports:
//   pc           in   current instruction address
//   instr_index  in   instr[25:0]; [15:0] doubles as the branch immediate
//   pc_sel       in   next-PC select code
//   rs_data      in   register rs value (jr target)
//   pc_plus4     out  pc + 4, also the jal link value
//   next_pc      out  selected next address
//   misalign     out  jr selected with a non-word-aligned target
module mips_next_pc
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [25:0]     instr_index,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] rs_data,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);

  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jump_target;

  // All additions wrap modulo 2^32 by construction of the operand widths.
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + branch_offset(instr_index[15:0]);
  // Pseudo-direct jump keeps the 256 MB region of the delay-slot address.
  assign jump_target   = {pc_plus4[31:28], instr_index, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (pc_sel)
      PC_SEL_SEQ: next_pc = pc_plus4;
      PC_SEL_BR:  next_pc = branch_target;
      PC_SEL_JR:  next_pc = rs_data;
      PC_SEL_J:   next_pc = jump_target;
      default:    next_pc = pc_plus4;
    endcase
  end

  assign misalign = (pc_sel == PC_SEL_JR) && (rs_data[1:0] != 2'b00);

endmodule

// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - instruction fetch and program-counter stage
//
// Purpose: owns the PC, fetches one instruction word at a time over a
// req/rvalid handshake, holds it in the instruction register until the
// datapath retires it, then advances the PC using the control unit's select.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req/imem_addr    fetch request and byte address (= pc)
//   imem_rvalid/rdata/err returned word and bus error
//   instr, op, func       instruction register and decoded fields
//   instr_valid           instr holds an unretired instruction
//   pc, pc_plus4          current address and pc + 4
//   retire, pc_sel        datapath completion and next-PC select
//   rs_data               jr target
//   fetch_err             sticky error; core halted until reset
//   instret               retired-instruction counter
// RESET_PC must be word-aligned.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_err,
  output logic [XLEN-1:0] instr,
  output logic [5:0]      op,
  output logic [5:0]      func,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            retire,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] rs_data,
  output logic            fetch_err,
  output logic [XLEN-1:0] instret
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] instret_q;
  logic [XLEN-1:0] next_pc;
  logic            misalign;
  logic            load_instr;
  logic            advance_pc;
  logic            bump_instret;

  mips_next_pc u_next_pc (
    .pc          (pc_q),
    .instr_index (instr_q[25:0]),
    .pc_sel      (pc_sel),
    .rs_data     (rs_data),
    .pc_plus4    (pc_plus4),
    .next_pc     (next_pc),
    .misalign    (misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Rvalid is only honoured in FETCH and retire only in EXEC, so stray
  // handshakes in any other state (including BOOT right after reset) fall
  // through to the default hold.
  always_comb begin
    state_d      = state_q;
    load_instr   = 1'b0;
    advance_pc   = 1'b0;
    bump_instret = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_rvalid) begin
          if (imem_err) begin
            state_d = ST_HALT;
          end else begin
            load_instr = 1'b1;
            state_d    = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (retire) begin
          // A misaligned jr still counts as retired but leaves pc on the
          // offending instruction for post-mortem inspection.
          bump_instret = 1'b1;
          if (misalign) begin
            state_d = ST_HALT;
          end else begin
            advance_pc = 1'b1;
            state_d    = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= {RESET_PC[31:2], 2'b00};
      instr_q   <= '0;
      instret_q <= '0;
    end else begin
      if (load_instr) begin
        instr_q <= imem_rdata;
      end
      if (advance_pc) begin
        pc_q <= next_pc;
      end
      if (bump_instret) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  // Handshake/status outputs are pure decodes of the state register.
  assign imem_req    = (state_q == ST_FETCH);
  assign instr_valid = (state_q == ST_EXEC);
  assign fetch_err   = (state_q == ST_HALT);

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign op        = instr_q[31:26];
  assign func      = instr_q[5:0];
  assign instret   = instret_q;

endmodule
